dram_burst_ctrl: RTL and testbench

DRAM_BURST_CTRL -- requirements
Module: dram_burst_ctrl

---
 rtl/dram_pkg.sv | 20 ++
 rtl/dram_array.sv | 21 ++
 rtl/dram_burst_ctrl.sv | 123 ++++++++++++
 tb/tb_dram_burst_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM line-burst controller.
package dram_pkg;

  // Command encodings on req_cmd
  localparam logic DRAM_RD = 1'b0;  // line fill
  localparam logic DRAM_WR = 1'b1;  // line writeback

  // Line geometry: 8 x 64-bit beats per 512-bit line
  localparam int BEATS     = 8;
  localparam int LINE_BITS = 512;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/dram_array.sv
// Single-port 64-bit synchronous RAM, one-cycle read latency, contents not reset.
module dram_array #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  // Write on we; registered read returns the pre-write word of the addressed row
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dram_burst_ctrl.sv
// Line-burst DRAM controller: accepts one 512-bit line request at a time,
// waits LATENCY cycles, then streams 8 ascending 64-bit beats to or from
// the backing array and pulses done.
module dram_burst_ctrl
  import dram_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int BEATS     = dram_pkg::BEATS,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cmd,
  input  logic [31:0] req_addr,
  input  logic [63:0] wr_data,
  output logic        wr_beat,
  output logic [63:0] rd_data,
  output logic        strobe,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_bursts,
  output logic [31:0] wr_bursts
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int BW  = $clog2(BEATS);
  localparam int LSB = $clog2(LINE_BITS / 8);

  state_t            state;
  logic              cmd_q;
  logic [31-LSB:0]   line_q;
  logic [3:0]        lat_cnt;
  logic [BW-1:0]     beat;
  logic [AW-1:0]     wr_addr_q;
  logic [AW-1:0]     beat_addr;
  logic [AW-1:0]     mem_addr;
  logic [63:0]       mem_q;
  logic              unused_addr_bits;

  // Byte offset within the line carries no information for a line request
  assign unused_addr_bits = ^req_addr[LSB-1:0];

  // Word of the current beat; truncation makes upper line bits alias
  assign beat_addr = AW'({line_q, beat});

  // Writes use the address registered alongside wr_beat; otherwise the
  // array reads the current beat so its data lines up with next-cycle strobe
  assign mem_addr  = wr_beat ? wr_addr_q : beat_addr;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Array output is already registered; gating keeps rd_data at 0 off-beat
  assign rd_data   = strobe ? mem_q : '0;

  dram_array #(.WORDS(MEM_WORDS)) u_array (
    .clk   (clk),
    .we    (wr_beat),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (mem_q)
  );

  // Burst FSM with registered beat/done outputs (one cycle behind state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= DRAM_RD;
      line_q    <= '0;
      lat_cnt   <= '0;
      beat      <= '0;
      wr_addr_q <= '0;
      strobe    <= 1'b0;
      wr_beat   <= 1'b0;
      done      <= 1'b0;
      rd_bursts <= '0;
      wr_bursts <= '0;
    end else begin
      strobe  <= 1'b0;
      wr_beat <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q   <= req_cmd;
            line_q  <= req_addr[31:LSB];
            lat_cnt <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            beat  <= '0;
            state <= (cmd_q == DRAM_WR) ? WRITE : READ;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        READ: begin
          strobe <= 1'b1;
          beat   <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) state <= DONE;
        end
        WRITE: begin
          wr_beat   <= 1'b1;
          wr_addr_q <= beat_addr;
          beat      <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) state <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          if (cmd_q == DRAM_WR) wr_bursts <= wr_bursts + 32'd1;
          else                  rd_bursts <= rd_bursts + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Directed bench for dram_burst_ctrl: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_dram_burst_ctrl;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rv0, rr0, cmd0, wb0, st0, busy0, dn0;
  logic [31:0] addr0, rdb0, wrb0;
  logic [63:0] wd0, rd0;
  logic        rv1, rr1, cmd1, wb1, st1, busy1, dn1;
  logic [31:0] addr1, rdb1, wrb1;
  logic [63:0] wd1, rd1;

  dram_burst_ctrl #(.LATENCY(4), .BEATS(8), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_cmd(cmd0),
    .req_addr(addr0), .wr_data(wd0), .wr_beat(wb0), .rd_data(rd0), .strobe(st0),
    .busy(busy0), .done(dn0), .rd_bursts(rdb0), .wr_bursts(wrb0)
  );

  dram_burst_ctrl #(.LATENCY(1), .BEATS(8), .MEM_WORDS(1024)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_cmd(cmd1),
    .req_addr(addr1), .wr_data(wd1), .wr_beat(wb1), .rd_data(rd1), .strobe(st1),
    .busy(busy1), .done(dn1), .rd_bursts(rdb1), .wr_bursts(wrb1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] wbuf [8];
  logic [63:0] rbuf [8];
  logic [23:0] o_st, o_wb, o_dn, o_busy;
  logic        rd_nz;
  int          n_rd;

  // Bit c set for cycles lo..hi relative to the handshake edge
  function automatic logic [23:0] win(input int lo, input int hi);
    logic [23:0] m;
    m = '0;
    for (int c = 0; c < 24; c++) m[c] = (c >= lo) && (c <= hi);
    return m;
  endfunction

  // One handshake then 24 observed cycles; bit c = cycle starting at E0+c
  task automatic burst(input int which, input logic cmd, input logic [31:0] addr);
    int wi;
    logic s, w, d, b;
    logic [63:0] r;
    wi = 0; n_rd = 0; rd_nz = 1'b0;
    o_st = '0; o_wb = '0; o_dn = '0; o_busy = '0;
    @(negedge clk);
    if (which == 0) begin rv0 = 1'b1; cmd0 = cmd; addr0 = addr; end
    else            begin rv1 = 1'b1; cmd1 = cmd; addr1 = addr; end
    @(posedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      rv0 = 1'b0; rv1 = 1'b0;
      s = (which == 0) ? st0   : st1;
      w = (which == 0) ? wb0   : wb1;
      d = (which == 0) ? dn0   : dn1;
      b = (which == 0) ? busy0 : busy1;
      r = (which == 0) ? rd0   : rd1;
      o_st[c] = s; o_wb[c] = w; o_dn[c] = d; o_busy[c] = b;
      if (s) begin
        if (n_rd < 8) rbuf[n_rd] = r;
        n_rd++;
      end else if (r !== 64'd0) rd_nz = 1'b1;
      if (w) begin
        if (which == 0) wd0 = wbuf[wi % 8]; else wd1 = wbuf[wi % 8];
        wi++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (rr0 !== 1'b1)   begin n_bad++; $display("FAIL reset_req_ready got %b want 1", rr0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_cmp++; if (st0 !== 1'b0)   begin n_bad++; $display("FAIL reset_strobe got %b want 0", st0); end
    n_cmp++; if (wb0 !== 1'b0)   begin n_bad++; $display("FAIL reset_wr_beat got %b want 0", wb0); end
    n_cmp++; if (dn0 !== 1'b0)   begin n_bad++; $display("FAIL reset_done got %b want 0", dn0); end
    n_cmp++; if (rd0 !== 64'd0)  begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rd0); end
    n_cmp++; if (rdb0 !== 32'd0) begin n_bad++; $display("FAIL reset_rd_bursts got %0d want 0", rdb0); end
    n_cmp++; if (wrb0 !== 32'd0) begin n_bad++; $display("FAIL reset_wr_bursts got %0d want 0", wrb0); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    for (int b = 0; b < 8; b++) wbuf[b] = 64'h1111111111111111 * 64'(b + 1);
    burst(0, DRAM_WR, 32'h0000_0040);
    n_cmp++; if (o_wb !== win(5, 12))  begin n_bad++; $display("FAIL wr_beat_window got %h want %h", o_wb, win(5, 12)); end
    n_cmp++; if (o_st !== 24'd0)       begin n_bad++; $display("FAIL wr_no_strobe got %h want 0", o_st); end
    n_cmp++; if (o_dn !== win(13, 13)) begin n_bad++; $display("FAIL wr_done got %h want %h", o_dn, win(13, 13)); end
    n_cmp++; if (o_busy !== win(0, 12)) begin n_bad++; $display("FAIL wr_busy got %h want %h", o_busy, win(0, 12)); end
    burst(0, DRAM_RD, 32'h0000_0040);
    n_cmp++; if (o_st !== win(5, 12))  begin n_bad++; $display("FAIL rd_strobe_window got %h want %h", o_st, win(5, 12)); end
    n_cmp++; if (o_wb !== 24'd0)       begin n_bad++; $display("FAIL rd_no_wr_beat got %h want 0", o_wb); end
    n_cmp++; if (o_dn !== win(13, 13)) begin n_bad++; $display("FAIL rd_done got %h want %h", o_dn, win(13, 13)); end
    n_cmp++; if (rd_nz !== 1'b0)       begin n_bad++; $display("FAIL rd_data_idle_zero got %b want 0", rd_nz); end
    for (int b = 0; b < 8; b++) begin
      n_cmp++;
      if (rbuf[b] !== 64'h1111111111111111 * 64'(b + 1)) begin
        n_bad++; $display("FAIL rd_beat%0d got %h want %h", b, rbuf[b], 64'h1111111111111111 * 64'(b + 1));
      end
    end
    n_cmp++; if (rdb0 !== 32'd1) begin n_bad++; $display("FAIL wr_rd_rd_bursts got %0d want 1", rdb0); end
    n_cmp++; if (wrb0 !== 32'd1) begin n_bad++; $display("FAIL wr_rd_wr_bursts got %0d want 1", wrb0); end
  endtask

  task automatic test_alias();
    for (int b = 0; b < 8; b++) wbuf[b] = 64'hA5A5_5A5A_0000_0000 + 64'(b);
    burst(0, DRAM_WR, 32'h0000_0000);
    burst(0, DRAM_RD, 32'h0000_2000);
    for (int b = 0; b < 8; b++) begin
      n_cmp++;
      if (rbuf[b] !== 64'hA5A5_5A5A_0000_0000 + 64'(b)) begin
        n_bad++; $display("FAIL alias_beat%0d got %h want %h", b, rbuf[b], 64'hA5A5_5A5A_0000_0000 + 64'(b));
      end
    end
    n_cmp++; if (rdb0 !== 32'd2) begin n_bad++; $display("FAIL alias_rd_bursts got %0d want 2", rdb0); end
    n_cmp++; if (wrb0 !== 32'd2) begin n_bad++; $display("FAIL alias_wr_bursts got %0d want 2", wrb0); end
  endtask

  task automatic test_busy_reject();
    int hs [4];
    int nhs, nst, ndn, novl;
    nhs = 0; nst = 0; ndn = 0; novl = 0;
    @(negedge clk);
    rv0 = 1'b1; cmd0 = DRAM_RD; addr0 = 32'h0000_0040;
    for (int i = 0; i < 42; i++) begin
      if (rr0) begin
        if (nhs < 4) hs[nhs] = i;
        nhs++;
      end
      if (st0) nst++;
      if (dn0) ndn++;
      if (st0 && wb0) novl++;
      @(negedge clk);
    end
    rv0 = 1'b0;
    n_cmp++; if (nhs !== 3) begin n_bad++; $display("FAIL busy_handshakes got %0d want 3", nhs); end
    if (nhs >= 3) begin
      n_cmp++; if (hs[1] - hs[0] !== 14) begin n_bad++; $display("FAIL busy_spacing0 got %0d want 14", hs[1] - hs[0]); end
      n_cmp++; if (hs[2] - hs[1] !== 14) begin n_bad++; $display("FAIL busy_spacing1 got %0d want 14", hs[2] - hs[1]); end
    end
    n_cmp++; if (nst !== 24)  begin n_bad++; $display("FAIL busy_strobe_count got %0d want 24", nst); end
    n_cmp++; if (ndn !== 2)   begin n_bad++; $display("FAIL busy_done_count got %0d want 2", ndn); end
    n_cmp++; if (novl !== 0)  begin n_bad++; $display("FAIL busy_overlap got %0d want 0", novl); end
    n_cmp++; if (rdb0 !== 32'd3) begin n_bad++; $display("FAIL busy_rd_bursts got %0d want 3", rdb0); end
  endtask

  task automatic test_reset_mid_write();
    int wi;
    logic hit, saw_done;
    wi = 0; hit = 1'b0; saw_done = 1'b0;
    for (int b = 0; b < 8; b++) wbuf[b] = 64'hDEAD_BEEF_0000_0000 + 64'(b);
    @(negedge clk);
    rv0 = 1'b1; cmd0 = DRAM_WR; addr0 = 32'h0000_0040;
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rv0 = 1'b0;
      if (dn0) saw_done = 1'b1;
      if (wb0) begin
        wd0 = wbuf[wi % 8];
        if (wi == 3) begin
          rst = 1'b1;
          hit = 1'b1;
          break;
        end
        wi++;
      end
    end
    #1;
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL mid_wr_reached_beat3 got %b want 1", hit); end
    n_cmp++; if (wb0 !== 1'b0) begin n_bad++; $display("FAIL mid_wr_abort got %b want 0", wb0); end
    @(negedge clk);
    if (dn0) saw_done = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    if (dn0) saw_done = 1'b1;
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL mid_wr_no_done got %b want 0", saw_done); end
    n_cmp++; if (wrb0 !== 32'd0) begin n_bad++; $display("FAIL mid_wr_wr_bursts got %0d want 0", wrb0); end
    burst(0, DRAM_RD, 32'h0000_0040);
    for (int b = 0; b < 8; b++) begin
      logic [63:0] exp;
      exp = (b < 3) ? 64'hDEAD_BEEF_0000_0000 + 64'(b) : 64'h1111111111111111 * 64'(b + 1);
      n_cmp++;
      if (rbuf[b] !== exp) begin n_bad++; $display("FAIL mid_wr_word%0d got %h want %h", b, rbuf[b], exp); end
    end
    n_cmp++; if (rdb0 !== 32'd1) begin n_bad++; $display("FAIL mid_wr_rd_bursts got %0d want 1", rdb0); end
  endtask

  task automatic test_latency1();
    for (int b = 0; b < 8; b++) wbuf[b] = 64'h0123_4567_89AB_CDEF ^ 64'(b);
    burst(1, DRAM_WR, 32'h0000_0080);
    n_cmp++; if (o_wb !== win(2, 9))   begin n_bad++; $display("FAIL l1_wr_beat_window got %h want %h", o_wb, win(2, 9)); end
    n_cmp++; if (o_dn !== win(10, 10)) begin n_bad++; $display("FAIL l1_wr_done got %h want %h", o_dn, win(10, 10)); end
    burst(1, DRAM_RD, 32'h0000_0080);
    n_cmp++; if (o_st !== win(2, 9))   begin n_bad++; $display("FAIL l1_strobe_window got %h want %h", o_st, win(2, 9)); end
    n_cmp++; if (o_dn !== win(10, 10)) begin n_bad++; $display("FAIL l1_rd_done got %h want %h", o_dn, win(10, 10)); end
    for (int b = 0; b < 8; b++) begin
      n_cmp++;
      if (rbuf[b] !== (64'h0123_4567_89AB_CDEF ^ 64'(b))) begin
        n_bad++; $display("FAIL l1_beat%0d got %h want %h", b, rbuf[b], 64'h0123_4567_89AB_CDEF ^ 64'(b));
      end
    end
    n_cmp++; if (rdb1 !== 32'd1) begin n_bad++; $display("FAIL l1_rd_bursts got %0d want 1", rdb1); end
    n_cmp++; if (wrb1 !== 32'd1) begin n_bad++; $display("FAIL l1_wr_bursts got %0d want 1", wrb1); end
  endtask

  initial begin
    rv0 = 1'b0; cmd0 = 1'b0; addr0 = '0; wd0 = '0;
    rv1 = 1'b0; cmd1 = 1'b0; addr1 = '0; wd1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_write_read();
    test_alias();
    test_reset();
    test_busy_reject();
    test_reset_mid_write();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
